// File: rtl/pc_fetch.sv
// Program counter and next-PC generation for the single-cycle core.
// State advances on the falling clock edge, in lockstep with imem.
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_halt_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_pc_next,
    output logic        o_halted,
    output logic        o_addr_err,
    output logic [31:0] o_instret
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // First byte address past the end of instruction memory.
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_addr_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_cand;
    logic        w_eval;
    logic        w_fault;
    logic        w_retire;
    logic [31:0] w_pc_next;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jump_tgt = {w_pc_plus4[31:28], i_jump_index, 2'b00};
    assign w_br_tgt   = w_pc_plus4 + (i_branch_offset << 2);

    // Candidate target selection: jr > jump > branch > sequential.
    always_comb begin
        w_cand = w_pc_plus4;
        if (i_jr)
            w_cand = i_jr_target;
        else if (i_jump)
            w_cand = w_jump_tgt;
        else if (i_branch_taken)
            w_cand = w_br_tgt;
    end

    // Fault only matters when this cycle would actually move the PC.
    always_comb begin
        w_eval   = (r_state == S_RUN) && !i_stall && !i_halt_req;
        w_fault  = w_eval &&
                   ((w_cand[1:0] != 2'b00) || (w_cand >= LIMIT));
        w_retire = w_eval && !w_fault;
    end

    // Next-PC mux; a faulting address never reaches memory.
    always_comb begin
        w_pc_next = r_pc;
        if (!i_rstn)
            w_pc_next = RESET_PC;
        else if (w_retire)
            w_pc_next = w_cand;
    end

    // Next-state logic: halt request or fault freezes the core.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (i_halt_req || w_fault)
                    w_state_nxt = S_HALT;
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // PC register; holds whenever pc_next selects the current PC.
    always_ff @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_instret <= 32'd0;
        else if (w_retire)
            r_instret <= r_instret + 32'd1;
    end

    // Sticky address-fault flag.
    always_ff @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_addr_err <= 1'b0;
        else if (w_fault)
            r_addr_err <= 1'b1;
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_pc_next  = w_pc_next;
    assign o_halted   = (r_state == S_HALT);
    assign o_addr_err = r_addr_err;
    assign o_instret  = r_instret;

endmodule
